// File: rtl/zion_basic_circuit_lib_clr_skid_reg_if.sv
// Handshake bundle for the clearable skid register slice.
// The master side drives the upstream beat, the downstream ready and the flush.
interface zion_basic_circuit_lib_clr_skid_reg_if #(
  parameter int WIDTH = 8
);
  logic             iClr;
  logic             iVld;
  logic             oRdy;
  logic [WIDTH-1:0] iDat;
  logic             oVld;
  logic             iRdy;
  logic [WIDTH-1:0] oDat;
  logic [1:0]       oCnt;

  modport master (
    output iClr, iVld, iDat, iRdy,
    input  oRdy, oVld, oDat, oCnt
  );

  modport slave (
    input  iClr, iVld, iDat, iRdy,
    output oRdy, oVld, oDat, oCnt
  );
endinterface

// File: rtl/zion_basic_circuit_lib_clr_skid_reg.sv
// Two-entry valid/ready skid slice with synchronous flush.
// Handshake outputs come from the occupancy state only, so no comb path crosses.
module zion_basic_circuit_lib_clr_skid_reg #(
  parameter int           WIDTH    = 8,
  parameter logic [127:0] INI_DATA = '0
) (
  input logic clk,
  input logic rst,
  zion_basic_circuit_lib_clr_skid_reg_if.slave sif
);
  localparam logic [WIDTH-1:0] INI = INI_DATA[WIDTH-1:0];

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  state_t           stateNxt;
  logic [WIDTH-1:0] mainReg;
  logic [WIDTH-1:0] mainNxt;
  logic [WIDTH-1:0] skidReg;
  logic [WIDTH-1:0] skidNxt;
  logic             inAcc;
  logic             outAcc;

  assign sif.oVld = (state != EMPTY);
  assign sif.oRdy = (state != FULL);
  assign sif.oCnt = state;
  assign sif.oDat = mainReg;

  assign inAcc  = sif.iVld & sif.oRdy;
  assign outAcc = sif.oVld & sif.iRdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= EMPTY;
      mainReg <= INI;
      skidReg <= INI;
    end else begin
      state   <= stateNxt;
      mainReg <= mainNxt;
      skidReg <= skidNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    mainNxt  = mainReg;
    skidNxt  = skidReg;
    if (sif.iClr) begin
      stateNxt = EMPTY;
      mainNxt  = INI;
      skidNxt  = INI;
    end else begin
      unique case (state)
        EMPTY: begin
          if (inAcc) begin
            mainNxt  = sif.iDat;
            stateNxt = ONE;
          end
        end
        ONE: begin
          if (inAcc && outAcc) begin
            mainNxt = sif.iDat;
          end else if (inAcc) begin
            skidNxt  = sif.iDat;
            stateNxt = FULL;
          end else if (outAcc) begin
            stateNxt = EMPTY;
          end
        end
        FULL: begin
          if (outAcc) begin
            mainNxt  = skidReg;
            stateNxt = ONE;
          end
        end
        default: begin
          stateNxt = EMPTY;
          mainNxt  = INI;
          skidNxt  = INI;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_zion_basic_circuit_lib_clr_skid_reg.sv
// Bench for the clearable skid slice: queue model checked every cycle,
// directed scenarios with literal expectations, and parameter variants.
module tb_zion_basic_circuit_lib_clr_skid_reg;
  localparam logic [127:0] INI_M = 128'h5A;
  localparam logic [127:0] INI_1 = {128{1'b1}};
  localparam logic [127:0] INI_T =
    128'h1234_5678_9ABC_DEF0_0000_0000_0000_00AB;

  logic clk;
  logic rst;
  int   nVec;
  int   nErr;

  zion_basic_circuit_lib_clr_skid_reg_if #(.WIDTH(8)) bus ();
  zion_basic_circuit_lib_clr_skid_reg_if #(.WIDTH(1)) bw1 ();
  zion_basic_circuit_lib_clr_skid_reg_if #(.WIDTH(64)) bw64 ();
  zion_basic_circuit_lib_clr_skid_reg_if #(.WIDTH(8)) btr ();

  zion_basic_circuit_lib_clr_skid_reg #(
    .WIDTH(8), .INI_DATA(INI_M)
  ) dut (.clk(clk), .rst(rst), .sif(bus));

  zion_basic_circuit_lib_clr_skid_reg #(
    .WIDTH(1), .INI_DATA(INI_1)
  ) dut1 (.clk(clk), .rst(rst), .sif(bw1));

  zion_basic_circuit_lib_clr_skid_reg #(
    .WIDTH(64), .INI_DATA(INI_1)
  ) dut64 (.clk(clk), .rst(rst), .sif(bw64));

  zion_basic_circuit_lib_clr_skid_reg #(
    .WIDTH(8), .INI_DATA(INI_T)
  ) dutT (.clk(clk), .rst(rst), .sif(btr));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: FIFO of at most two beats plus the value left on the
  // output once the FIFO drains.
  logic [7:0] mq[$];
  logic [7:0] mLast = 8'h5A;
  bit         stallEdge = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst || bus.iClr) begin
      mq.delete();
      mLast = 8'h5A;
      stallEdge = 1'b0;
    end else begin
      automatic bit outA = (mq.size() != 0) && bus.iRdy;
      automatic bit inA  = bus.iVld && (mq.size() != 2);
      stallEdge = (mq.size() != 0) && !bus.iRdy;
      if (outA) mLast = mq.pop_front();
      if (inA) mq.push_back(bus.iDat);
    end
  end

  logic [7:0] prevDat;

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("vld", 64'(bus.oVld), 64'(mq.size() != 0));
      chk("rdy", 64'(bus.oRdy), 64'(mq.size() != 2));
      chk("cnt", 64'(bus.oCnt), 64'(mq.size()));
      chk("dat", 64'(bus.oDat),
          64'((mq.size() != 0) ? mq[0] : mLast));
      chk("rdy_vs_cnt", 64'(bus.oRdy), 64'(bus.oCnt != 2'd2));
      if (stallEdge) chk("stall_stable", 64'(bus.oDat), 64'(prevDat));
    end
    prevDat = bus.oDat;
  end

  task automatic drive(input bit clr, input bit vld,
                       input logic [7:0] dat, input bit rdy);
    @(negedge clk);
    bus.iClr = clr;
    bus.iVld = vld;
    bus.iDat = dat;
    bus.iRdy = rdy;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nVec = 0;
    nErr = 0;
    rst  = 1'b1;
    bus.iClr = 1'b0; bus.iVld = 1'b0;
    bus.iDat = 8'h00; bus.iRdy = 1'b0;
    bw1.iClr = 1'b0; bw1.iVld = 1'b1;
    bw1.iDat = 1'b0; bw1.iRdy = 1'b0;
    bw64.iClr = 1'b0; bw64.iVld = 1'b1;
    bw64.iDat = 64'h0; bw64.iRdy = 1'b0;
    btr.iClr = 1'b0; btr.iVld = 1'b1;
    btr.iDat = 8'h00; btr.iRdy = 1'b0;
    #3;
    chk("rst_vld", 64'(bus.oVld), 64'd0);
    chk("rst_rdy", 64'(bus.oRdy), 64'd1);
    chk("rst_cnt", 64'(bus.oCnt), 64'd0);
    chk("rst_dat", 64'(bus.oDat), 64'h5A);
    chk("w1_rst", 64'(bw1.oDat), 64'h1);
    chk("w64_rst", bw64.oDat, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("trunc_rst", 64'(btr.oDat), 64'hAB);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // streaming
    for (int i = 1; i <= 6; i++) begin
      drive(0, 1, 8'(i), 1);
      edge1();
      chk("stream_dat", 64'(bus.oDat), 64'(i));
      chk("stream_cnt", 64'(bus.oCnt), 64'd1);
    end
    drive(0, 0, 8'hEE, 1);
    edge1();
    chk("drain_cnt", 64'(bus.oCnt), 64'd0);
    chk("drain_dat", 64'(bus.oDat), 64'd6);

    // parameter variants are full by now
    chk("w1_fill", 64'(bw1.oDat), 64'h0);
    chk("w64_fill", bw64.oDat, 64'h0);
    chk("w64_cnt", 64'(bw64.oCnt), 64'd2);
    chk("trunc_fill", 64'(btr.oDat), 64'h00);
    @(negedge clk);
    bw1.iClr = 1'b1; bw64.iClr = 1'b1; btr.iClr = 1'b1;
    edge1();
    chk("w1_clr", 64'(bw1.oDat), 64'h1);
    chk("w64_clr", bw64.oDat, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("w64_clr_cnt", 64'(bw64.oCnt), 64'd0);
    chk("trunc_clr", 64'(btr.oDat), 64'hAB);
    @(negedge clk);
    bw1.iClr = 1'b0; bw64.iClr = 1'b0; btr.iClr = 1'b0;

    // backpressure
    drive(0, 1, 8'hA5, 0);
    edge1();
    drive(0, 1, 8'h3C, 0);
    edge1();
    chk("bp_cnt", 64'(bus.oCnt), 64'd2);
    chk("bp_rdy", 64'(bus.oRdy), 64'd0);
    chk("bp_dat", 64'(bus.oDat), 64'hA5);
    drive(0, 1, 8'h77, 0);
    edge1();
    chk("bp_hold", 64'(bus.oDat), 64'hA5);
    drive(0, 0, 8'h00, 1);
    edge1();
    chk("bp_second", 64'(bus.oDat), 64'h3C);
    chk("bp_cnt1", 64'(bus.oCnt), 64'd1);
    edge1();
    chk("bp_cnt0", 64'(bus.oCnt), 64'd0);

    // flush while full, with a beat offered and taken
    drive(0, 1, 8'h11, 0);
    edge1();
    drive(0, 1, 8'h22, 0);
    edge1();
    drive(1, 1, 8'h33, 1);
    edge1();
    chk("clr_cnt", 64'(bus.oCnt), 64'd0);
    chk("clr_dat", 64'(bus.oDat), 64'h5A);
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 8'h33, 1);
      edge1();
      chk("clr_quiet", 64'(bus.oVld), 64'd0);
    end

    // async reset with two beats held
    drive(0, 1, 8'h44, 0);
    edge1();
    drive(0, 1, 8'h55, 0);
    edge1();
    chk("pre_rst_cnt", 64'(bus.oCnt), 64'd2);
    drive(0, 0, 8'h00, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_vld", 64'(bus.oVld), 64'd0);
    chk("arst_rdy", 64'(bus.oRdy), 64'd1);
    chk("arst_cnt", 64'(bus.oCnt), 64'd0);
    chk("arst_dat", 64'(bus.oDat), 64'h5A);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // random traffic with occasional flush
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom % 32) == 0,
            ($urandom % 4) != 0,
            8'($urandom),
            ($urandom % 3) != 0);
    end
    drive(0, 0, 8'h00, 1);
    @(negedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
